cubehash_msg_ctrl: RTL and testbench

- Sequencer that drives the CubeHash core's init/start/fetch/load/msg pins and observes its busy and hash outputs.
- Accepts a byte message as a 64-bit word stream and packs four words into each 256-bit block.
- Applies padding (0x80 then zeros to the block boundary) and absorbs each block through the core.
- Runs finalization, captures the 256-bit digest and presents it on a valid/ready output.

---
 rtl/cubehash_msg_ctrl.sv | 165 ++++++++++++++++
 tb/tb_cubehash_msg_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cubehash_msg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cubehash_msg_ctrl
// Purpose  : Packs a 64-bit message word stream into padded 256-bit blocks,
//            sequences the CubeHash core and returns the digest on valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module cubehash_msg_ctrl #(
    parameter int BLK_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [63:0]          s_data,
    input  logic                 s_last,
    input  logic [3:0]           s_bytes,
    output logic                 hash_valid,
    input  logic                 hash_ready,
    output logic [255:0]         hash_out,
    output logic [BLK_CNT_W-1:0] blk_count,
    output logic                 core_init,
    output logic                 core_start,
    output logic                 core_fetch,
    output logic                 core_load,
    output logic [255:0]         core_msg,
    input  logic                 core_busy,
    input  logic [255:0]         core_hash
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INIT      = 4'd1,
        S_INIT_WAIT = 4'd2,
        S_COLLECT   = 4'd3,
        S_ABSORB    = 4'd4,
        S_WAIT_ABS  = 4'd5,
        S_FINAL     = 4'd6,
        S_LOAD      = 4'd7,
        S_DONE      = 4'd8
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [1:0]     r_idx;
    logic           r_final;
    logic           r_pad;
    logic           r_first;
    logic [255:0]   r_buf;
    logic [255:0]   w_buf_next;
    logic [3:0]     w_nb;
    logic           w_accept;
    logic           w_last_full;

    always_comb begin
        w_accept    = (r_state == S_COLLECT) && s_valid;
        w_nb        = !s_last ? 4'd8 : ((s_bytes > 4'd8) ? 4'd8 : s_bytes);
        w_last_full = (r_idx == 2'd3) && (w_nb == 4'd8);
        w_buf_next  = r_buf;
        if (w_accept) begin
            // Current word is masked; on the last word every later byte is
            // cleared and the 0x80 marker lands directly after the data.
            for (int k = 0; k < 4; k++) begin
                for (int b = 0; b < 8; b++) begin
                    if (k == int'(r_idx)) begin
                        if (b < int'(w_nb))
                            w_buf_next[255-64*k-8*b -: 8] = s_data[63-8*b -: 8];
                        else
                            w_buf_next[255-64*k-8*b -: 8] = (b == int'(w_nb)) ? 8'h80 : 8'h00;
                    end else if (s_last && (k > int'(r_idx))) begin
                        w_buf_next[255-64*k-8*b -: 8] =
                            ((w_nb == 4'd8) && (k == int'(r_idx) + 1) && (b == 0)) ? 8'h80 : 8'h00;
                    end
                end
            end
        end else if ((r_state == S_WAIT_ABS) && !core_busy && !r_final && r_pad) begin
            w_buf_next = {8'h80, 248'd0};
        end

        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (s_valid) w_state_next = S_INIT;
            S_INIT:      w_state_next = S_INIT_WAIT;
            S_INIT_WAIT: w_state_next = S_COLLECT;
            S_COLLECT:   if (w_accept && (s_last || (r_idx == 2'd3))) w_state_next = S_ABSORB;
            S_ABSORB:    w_state_next = S_WAIT_ABS;
            S_WAIT_ABS: begin
                if (!core_busy) begin
                    if (r_final)    w_state_next = S_FINAL;
                    else if (r_pad) w_state_next = S_ABSORB;
                    else            w_state_next = S_COLLECT;
                end
            end
            // The first FINAL cycle is ignored: the core has not yet seen fetch.
            S_FINAL:     if (!r_first && !core_busy) w_state_next = S_LOAD;
            S_LOAD:      w_state_next = S_DONE;
            S_DONE:      if (hash_ready) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_final    <= 1'b0;
            r_pad      <= 1'b0;
            r_first    <= 1'b0;
            r_buf      <= '0;
            s_ready    <= 1'b0;
            hash_valid <= 1'b0;
            hash_out   <= '0;
            blk_count  <= '0;
            core_init  <= 1'b0;
            core_start <= 1'b0;
            core_fetch <= 1'b0;
            core_load  <= 1'b0;
            core_msg   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_buf      <= w_buf_next;
            r_first    <= (r_state != S_FINAL);
            s_ready    <= (w_state_next == S_COLLECT);
            core_init  <= (w_state_next == S_INIT);
            core_start <= (w_state_next == S_ABSORB);
            core_msg   <= (w_state_next == S_ABSORB) ? w_buf_next : '0;
            core_fetch <= (w_state_next == S_FINAL) || (w_state_next == S_LOAD);
            core_load  <= (w_state_next == S_LOAD);
            hash_valid <= (w_state_next == S_DONE);

            if (r_state == S_LOAD)
                hash_out <= core_hash;

            if (w_state_next == S_INIT)
                blk_count <= '0;
            else if (r_state == S_ABSORB)
                blk_count <= blk_count + 1'b1;

            if (r_state == S_INIT) begin
                r_idx   <= 2'd0;
                r_final <= 1'b0;
                r_pad   <= 1'b0;
            end else if (w_accept) begin
                if (s_last) begin
                    r_final <= !w_last_full;
                    r_pad   <= w_last_full;
                end else if (r_idx == 2'd3) begin
                    r_final <= 1'b0;
                    r_pad   <= 1'b0;
                end else begin
                    r_idx   <= r_idx + 2'd1;
                end
            end else if ((r_state == S_WAIT_ABS) && !core_busy && !r_final) begin
                if (r_pad) begin
                    r_final <= 1'b1;
                    r_pad   <= 1'b0;
                end else begin
                    r_idx   <= 2'd0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cubehash_msg_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cubehash_msg_ctrl
// Purpose  : Directed bench for cubehash_msg_ctrl with a small CubeHash core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cubehash_msg_ctrl;

    localparam int BLK_CNT_W = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic [63:0]          s_data = '0;
    logic                 s_last = 1'b0;
    logic [3:0]           s_bytes = '0;
    logic                 hash_valid;
    logic                 hash_ready = 1'b0;
    logic [255:0]         hash_out;
    logic [BLK_CNT_W-1:0] blk_count;
    logic                 core_init, core_start, core_fetch, core_load;
    logic [255:0]         core_msg;
    logic                 core_busy;
    logic [255:0]         core_hash = '0;

    cubehash_msg_ctrl #(.BLK_CNT_W(BLK_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .s_bytes(s_bytes),
        .hash_valid(hash_valid), .hash_ready(hash_ready), .hash_out(hash_out),
        .blk_count(blk_count),
        .core_init(core_init), .core_start(core_start), .core_fetch(core_fetch),
        .core_load(core_load), .core_msg(core_msg),
        .core_busy(core_busy), .core_hash(core_hash)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Core model: busy for 3 cycles after a start or the first fetch cycle.
    int             busy_cnt;
    bit             fetching;
    int             n_start = 0;
    int             n_init = 0;
    int             viol = 0;
    logic [255:0]   msgs[$];
    logic           prev_fetch, prev_load;

    assign core_busy = (busy_cnt != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt   <= 0;
            fetching   <= 1'b0;
            prev_fetch <= 1'b0;
            prev_load  <= 1'b0;
        end else begin
            if (core_start || (core_fetch && !fetching))
                busy_cnt <= 3;
            else if (busy_cnt != 0)
                busy_cnt <= busy_cnt - 1;
            if (core_load)
                fetching <= 1'b0;
            else if (core_fetch)
                fetching <= 1'b1;
            if (core_start) begin
                n_start <= n_start + 1;
                msgs.push_back(core_msg);
            end
            if (core_init)
                n_init <= n_init + 1;
            if ((!core_start && core_msg != '0) ||
                (int'(core_start) + int'(core_init) + int'(core_load) > 1) ||
                ((core_start || core_init) && core_busy) ||
                (prev_fetch && !core_fetch && !prev_load) ||
                (s_ready && (hash_valid || core_fetch || core_start || core_init)))
                viol <= viol + 1;
            prev_fetch <= core_fetch;
            prev_load  <= core_load;
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        s_bytes = nb;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("word_accept", {255'd0, ok}, 256'd1);
    endtask

    task automatic finish_msg(input logic [255:0] hv, input int blocks,
                              input logic [255:0] first, input logic [255:0] last,
                              input int s0, input int q0, input int i0, input bit hold);
        bit ok;
        bit bad;
        logic [255:0] h;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (hash_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("hash_valid_seen", {255'd0, ok}, 256'd1);
        chk("hash_out", hash_out, hv);
        chk("blk_count", blk_count, blocks);
        chk("start_count", n_start - s0, blocks);
        chk("init_count", n_init - i0, 1);
        chk("first_block", (msgs.size() > q0) ? msgs[q0] : 'x, first);
        chk("last_block", (msgs.size() > q0) ? msgs[msgs.size()-1] : 'x, last);
        chk("s_ready_in_done", {255'd0, s_ready}, 256'd0);
        if (hold) begin
            h = hash_out;
            bad = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (!hash_valid || hash_out !== h || s_ready || core_fetch) bad = 1'b1;
            end
            chk("hold_stable", {255'd0, bad}, 256'd0);
        end
        @(posedge clk);
        #1;
        hash_ready = 1'b1;
        @(posedge clk);
        #1;
        hash_ready = 1'b0;
        chk("hash_valid_drop", {255'd0, hash_valid}, 256'd0);
    endtask

    // Bytes of a message are 0x01, 0x02, ...; unused lanes carry 0xEE.
    task automatic run_msg(input int n, input int blocks, input logic [255:0] first,
                           input logic [255:0] last, input logic [255:0] hv);
        int words, s0, q0, i0;
        logic [63:0] d;
        s0 = n_start;
        q0 = msgs.size();
        i0 = n_init;
        core_hash = hv;
        words = (n == 0) ? 1 : (n + 7) / 8;
        for (int w = 0; w < words; w++) begin
            for (int b = 0; b < 8; b++)
                d[63-8*b -: 8] = (8*w + b < n) ? 8'(8*w + b + 1) : 8'hEE;
            send_word(d, (w == words - 1), (w == words - 1) ? 4'(n - 8*w) : 4'd8);
        end
        finish_msg(hv, blocks, first, last, s0, q0, i0, 1'b0);
    endtask

    typedef struct {
        int           nbytes;
        int           blocks;
        logic [255:0] first;
        logic [255:0] last;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int s0, q0, i0;
        bit ok;

        tbl[0] = '{0, 1, {8'h80, 248'd0}, {8'h80, 248'd0}};
        tbl[1] = '{19, 1,
            256'h0102030405060708_090A0B0C0D0E0F10_1112138000000000_0000000000000000,
            256'h0102030405060708_090A0B0C0D0E0F10_1112138000000000_0000000000000000};
        tbl[2] = '{32, 2,
            256'h0102030405060708_090A0B0C0D0E0F10_1112131415161718_191A1B1C1D1E1F20,
            {8'h80, 248'd0}};
        tbl[3] = '{24, 1,
            256'h0102030405060708_090A0B0C0D0E0F10_1112131415161718_8000000000000000,
            256'h0102030405060708_090A0B0C0D0E0F10_1112131415161718_8000000000000000};
        tbl[4] = '{31, 1,
            256'h0102030405060708_090A0B0C0D0E0F10_1112131415161718_191A1B1C1D1E1F80,
            256'h0102030405060708_090A0B0C0D0E0F10_1112131415161718_191A1B1C1D1E1F80};
        tbl[5] = '{33, 2,
            256'h0102030405060708_090A0B0C0D0E0F10_1112131415161718_191A1B1C1D1E1F20,
            256'h2180000000000000_0000000000000000_0000000000000000_0000000000000000};
        tbl[6] = '{40, 2,
            256'h0102030405060708_090A0B0C0D0E0F10_1112131415161718_191A1B1C1D1E1F20,
            256'h2122232425262728_8000000000000000_0000000000000000_0000000000000000};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {242'd0, s_ready, hash_valid, core_init, core_start, core_fetch, core_load, 8'd0},
            256'd0);
        chk("reset_blk_count", blk_count, 256'd0);
        chk("reset_hash_out", hash_out, 256'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++)
            run_msg(tbl[i].nbytes, tbl[i].blocks, tbl[i].first, tbl[i].last,
                    {8{32'hA5000000 + 32'(i)}});

        // 8-byte message with s_bytes above 8, then digest held for 20 cycles.
        s0 = n_start;
        q0 = msgs.size();
        i0 = n_init;
        core_hash = {8{32'h5A5A0008}};
        send_word(64'h0123456789ABCDEF, 1'b1, 4'd15);
        finish_msg({8{32'h5A5A0008}}, 1,
                   256'h0123456789ABCDEF_8000000000000000_0000000000000000_0000000000000000,
                   256'h0123456789ABCDEF_8000000000000000_0000000000000000_0000000000000000,
                   s0, q0, i0, 1'b1);

        // Reset asserted while the controller is in the fetch phase.
        core_hash = {8{32'hDEAD0001}};
        send_word(64'hEEEEEEEEEEEEEEEE, 1'b1, 4'd0);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (core_fetch) begin
                ok = 1'b1;
                break;
            end
        end
        chk("fetch_reached", {255'd0, ok}, 256'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", {250'd0, s_ready, hash_valid, core_init, core_start, core_fetch, core_load},
            256'd0);
        chk("async_rst_blk_count", blk_count, 256'd0);
        chk("async_rst_hash_out", hash_out, 256'd0);
        chk("async_rst_core_msg", core_msg, 256'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_msg(tbl[1].nbytes, tbl[1].blocks, tbl[1].first, tbl[1].last, {8{32'h0BADF00D}});

        chk("protocol_violations", viol, 256'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
